nand_target_model: RTL and testbench



---
 rtl/nand_target_model.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_nand_target_model.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_target_model.sv
// NAND flash target: decodes the flash pin bus against a small page-organised array.
// Define NAND_TARGET_READ_ID_EN to add the READ ID (90h) command.
module nand_target_model #(
  parameter int unsigned COL_AW  = 4,
  parameter int unsigned ROW_AW  = 4,
  parameter int unsigned T_READ  = 32,
  parameter int unsigned T_RST   = 16,
  parameter logic [7:0]  IDLE_DQ = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_n,
  input  logic       cle,
  input  logic       ale,
  input  logic       we_n,
  input  logic       re_n,
  input  logic       wp_n,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rb_n,
  output logic       cmd_err
);

  localparam int unsigned PAGE_BYTES = 2**COL_AW;
  localparam int unsigned ROWS = 2**ROW_AW;
  localparam int unsigned T_MAX0 =
    (T_READ > T_RST) ? T_READ : T_RST;
  localparam int unsigned T_MAX =
    (T_MAX0 > PAGE_BYTES) ? T_MAX0 : PAGE_BYTES;
  localparam int unsigned CW = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_RD,
    S_ADDR_PG,
    S_DIN,
    S_BUSY_RD,
    S_BUSY_PG,
    S_BUSY_RST,
    S_DOUT,
    S_STATUS,
    S_ADDR_ID,
    S_ID
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_PG,
    OP_RST
  } op_t;

  state_t state, state_d;
  op_t op;

  logic [CW-1:0]     cnt;
  logic [COL_AW-1:0] col;
  logic [COL_AW-1:0] cp;
  logic [ROW_AW-1:0] row;
  logic [1:0]        acnt;
  logic              fail;
  logic              we_n_q;
  logic              re_n_q;

  logic [7:0] mem  [ROWS*PAGE_BYTES];
  logic [7:0] pbuf [PAGE_BYTES];

  logic wr_evt, rd_evt;
  logic is_cmd, is_adr, is_dat, is_bad;
  logic bsy, done;
  logic err, go_rd, go_pg, go_rst;
  logic go_adr, pg_fill, fail_set;
  logic adr_ok, dat_ok, out_st;
  logic [7:0] status;

  assign wr_evt = ~ce_n & ~we_n_q & we_n;
  assign rd_evt = ~ce_n & ~re_n_q & re_n;

  assign is_cmd = wr_evt & cle & ~ale;
  assign is_adr = wr_evt & ale & ~cle;
  assign is_dat = wr_evt & ~cle & ~ale;
  assign is_bad = wr_evt & cle & ale;

  assign bsy  = (op != OP_NONE);
  assign done = bsy & (cnt == CW'(1));

  assign adr_ok = is_adr &
    ((state == S_ADDR_RD) | (state == S_ADDR_PG));
  assign dat_ok = is_dat &
    ((state == S_ADDR_PG) | (state == S_DIN));

  // Bit 7 reads 1 when the die is not write protected
  assign status = {wp_n, rb_n, rb_n, 4'b0000, fail};

`ifdef NAND_TARGET_READ_ID_EN
  logic       go_id;
  logic [1:0] id_idx;
  logic [7:0] id_byte;

  always_comb begin
    id_byte = 8'h95;
    unique case (id_idx)
      2'd0:    id_byte = 8'hEC;
      2'd1:    id_byte = 8'hDA;
      2'd2:    id_byte = 8'h10;
      default: id_byte = 8'h95;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_idx <= '0;
    end else if (go_id) begin
      id_idx <= '0;
    end else if (rd_evt && state == S_ID) begin
      id_idx <= id_idx + 2'd1;
    end
  end
`endif

  always_comb begin
    out_st = (state == S_DOUT) | (state == S_STATUS);
`ifdef NAND_TARGET_READ_ID_EN
    out_st = out_st | (state == S_ID);
`endif
  end

  assign dq_oe = ~ce_n & ~re_n & out_st;

  always_comb begin
    state_d  = state;
    err      = 1'b0;
    go_rd    = 1'b0;
    go_pg    = 1'b0;
    go_rst   = 1'b0;
    go_adr   = 1'b0;
    pg_fill  = 1'b0;
    fail_set = 1'b0;
`ifdef NAND_TARGET_READ_ID_EN
    go_id    = 1'b0;
`endif
    if (done) begin
      if (state == S_BUSY_RD) begin
        state_d = S_DOUT;
      end else if (state == S_BUSY_PG ||
                   state == S_BUSY_RST) begin
        state_d = S_IDLE;
      end
    end
    unique case (1'b1)
      is_bad: err = 1'b1;
      is_cmd: begin
        if (dq_in == 8'hFF) begin
          go_rst  = 1'b1;
          state_d = S_BUSY_RST;
        end else if (dq_in == 8'h70) begin
          state_d = S_STATUS;
        end else if (bsy) begin
          // Busy operation runs on; only flag it
          err = 1'b1;
        end else begin
          state_d = S_IDLE;
          case (dq_in)
            8'h00: begin
              if (state == S_IDLE) begin
                go_adr  = 1'b1;
                state_d = S_ADDR_RD;
              end else if (state == S_STATUS) begin
                state_d = S_DOUT;
              end else begin
                err = 1'b1;
              end
            end
            8'h30: begin
              if (state == S_ADDR_RD &&
                  acnt == 2'd2) begin
                go_rd   = 1'b1;
                state_d = S_BUSY_RD;
              end else begin
                err = 1'b1;
              end
            end
            8'h80: begin
              if (state == S_IDLE ||
                  state == S_DOUT) begin
                go_adr  = 1'b1;
                pg_fill = 1'b1;
                state_d = S_ADDR_PG;
              end else begin
                err = 1'b1;
              end
            end
            8'h10: begin
              if (state == S_ADDR_PG ||
                  state == S_DIN) begin
                if (wp_n) begin
                  go_pg   = 1'b1;
                  state_d = S_BUSY_PG;
                end else begin
                  fail_set = 1'b1;
                  err      = 1'b1;
                end
              end else begin
                err = 1'b1;
              end
            end
`ifdef NAND_TARGET_READ_ID_EN
            8'h90: begin
              go_id   = 1'b1;
              state_d = S_ADDR_ID;
            end
`endif
            default: err = 1'b1;
          endcase
        end
      end
`ifdef NAND_TARGET_READ_ID_EN
      is_adr: begin
        if (state == S_ADDR_ID) begin
          if (dq_in == 8'h00) begin
            state_d = S_ID;
          end else begin
            err     = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      is_dat: begin
        if (state == S_ADDR_PG) state_d = S_DIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op      <= OP_NONE;
      cnt     <= '0;
      cp      <= '0;
      col     <= '0;
      row     <= '0;
      acnt    <= '0;
      fail    <= 1'b0;
      we_n_q  <= 1'b1;
      re_n_q  <= 1'b1;
      rb_n    <= 1'b1;
      cmd_err <= 1'b0;
      dq_out  <= IDLE_DQ;
    end else begin
      we_n_q  <= we_n;
      re_n_q  <= re_n;
      state   <= state_d;
      cmd_err <= err;
      rb_n    <= ~(go_rd | go_pg | go_rst |
                   (bsy & ~done));

      if (go_rst) begin
        op  <= OP_RST;
        cnt <= CW'(T_RST);
      end else if (go_rd) begin
        op  <= OP_RD;
        cnt <= CW'(T_READ);
      end else if (go_pg) begin
        op  <= OP_PG;
        cnt <= CW'(PAGE_BYTES);
      end else if (done) begin
        op  <= OP_NONE;
        cnt <= '0;
      end else if (bsy) begin
        cnt <= cnt - CW'(1);
      end

      if (go_pg) begin
        cp <= '0;
      end else if (op == OP_PG) begin
        cp <= cp + 1'b1;
      end

      if (go_rst | pg_fill) begin
        fail <= 1'b0;
      end else if (fail_set) begin
        fail <= 1'b1;
      end

      if (go_adr) begin
        acnt <= '0;
      end else if (adr_ok && acnt != 2'd2) begin
        acnt <= acnt + 2'd1;
      end

      if (adr_ok && acnt == 2'd0) begin
        col <= dq_in[COL_AW-1:0];
      end else if (dat_ok ||
                   (rd_evt && state == S_DOUT)) begin
        col <= col + 1'b1;
      end

      if (adr_ok && acnt == 2'd1) begin
        row <= dq_in[ROW_AW-1:0];
      end

      unique case (state)
        S_DOUT:   dq_out <= mem[{row, col}];
        S_STATUS: dq_out <= status;
`ifdef NAND_TARGET_READ_ID_EN
        S_ID:     dq_out <= id_byte;
`endif
        default:  dq_out <= IDLE_DQ;
      endcase
    end
  end

  // Storage carries no reset; program copies one byte per busy cycle
  always_ff @(posedge clk) begin
    if (op == OP_PG) begin
      mem[{row, cp}] <= pbuf[cp];
    end
  end

  always_ff @(posedge clk) begin
    if (pg_fill) begin
      for (int i = 0; i < PAGE_BYTES; i++) begin
        pbuf[i] <= 8'hFF;
      end
    end else if (dat_ok) begin
      pbuf[col] <= dq_in;
    end
  end

endmodule

// File: tb/tb_nand_target_model.sv
// Directed bench for nand_target_model: program, read, status,
// write protect, column wrap, illegal cycles and reset.
module tb_nand_target_model;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce_n = 1'b1;
  logic       cle = 1'b0;
  logic       ale = 1'b0;
  logic       we_n = 1'b1;
  logic       re_n = 1'b1;
  logic       wp_n = 1'b1;
  logic [7:0] dq_in = 8'h00;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rb_n;
  logic       cmd_err;

  int n_chk = 0;
  int n_fail = 0;
  int n;
  logic       err;
  logic [7:0] v;
  logic       oe;

  always #5 clk = ~clk;

  nand_target_model dut (
    .clk     (clk),
    .rst     (rst),
    .ce_n    (ce_n),
    .cle     (cle),
    .ale     (ale),
    .we_n    (we_n),
    .re_n    (re_n),
    .wp_n    (wp_n),
    .dq_in   (dq_in),
    .dq_out  (dq_out),
    .dq_oe   (dq_oe),
    .rb_n    (rb_n),
    .cmd_err (cmd_err)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic c, input logic a,
                    input logic [7:0] d);
    @(negedge clk);
    cle = c;
    ale = a;
    dq_in = d;
    we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
    err = cmd_err;
    cle = 1'b0;
    ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);
    wr(1'b1, 1'b0, d);
  endtask

  task automatic adr(input logic [7:0] d);
    wr(1'b0, 1'b1, d);
  endtask

  task automatic dat(input logic [7:0] d);
    wr(1'b0, 1'b0, d);
  endtask

  task automatic rd();
    @(negedge clk);
    re_n = 1'b0;
    @(negedge clk);
    v = dq_out;
    oe = dq_oe;
    re_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rdy();
    n = 0;
    while (rb_n === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rb_n", {7'd0, rb_n}, 8'h01);
    chk("rst_dq_oe", {7'd0, dq_oe}, 8'h00);
    chk("rst_dq_out", dq_out, 8'hAA);
    chk("rst_cmd_err", {7'd0, cmd_err}, 8'h00);
    rst = 1'b1;
    ce_n = 1'b0;

    // program row 5 from col 3
    cmd(8'h80);
    adr(8'h03);
    adr(8'h05);
    dat(8'h11);
    dat(8'h22);
    dat(8'h33);
    cmd(8'h10);
    chk("pg_err", {7'd0, err}, 8'h00);
    wait_rdy();
    chk("pg_busy_len", 8'(n), 8'd16);

    cmd(8'h00);
    adr(8'h03);
    adr(8'h05);
    cmd(8'h30);
    wait_rdy();
    chk("rd_busy_len", 8'(n), 8'd32);
    rd();
    chk("rd_b0", v, 8'h11);
    chk("rd_oe", {7'd0, oe}, 8'h01);
    rd();
    chk("rd_b1", v, 8'h22);
    rd();
    chk("rd_b2", v, 8'h33);
    rd();
    chk("rd_b3_erased", v, 8'hFF);

    // write protected program
    cmd(8'hFF);
    wait_rdy();
    chk("rst_busy_len", 8'(n), 8'd16);
    wp_n = 1'b0;
    cmd(8'h80);
    adr(8'h03);
    adr(8'h05);
    dat(8'h44);
    dat(8'h55);
    dat(8'h66);
    cmd(8'h10);
    chk("wp_err", {7'd0, err}, 8'h01);
    chk("wp_rb_n", {7'd0, rb_n}, 8'h01);
    cmd(8'h70);
    rd();
    chk("wp_status", v, 8'h61);
    cmd(8'hFF);
    wait_rdy();
    wp_n = 1'b1;
    cmd(8'h00);
    adr(8'h03);
    adr(8'h05);
    cmd(8'h30);
    wait_rdy();
    rd();
    chk("wp_unchanged", v, 8'h11);

    // column wrap, program issued from DOUT
    cmd(8'h80);
    adr(8'h0F);
    adr(8'h02);
    dat(8'h5A);
    dat(8'hA5);
    cmd(8'h10);
    chk("wrap_pg_err", {7'd0, err}, 8'h00);
    wait_rdy();
    cmd(8'h00);
    adr(8'h0F);
    adr(8'h02);
    cmd(8'h30);
    wait_rdy();
    rd();
    chk("wrap_b15", v, 8'h5A);
    rd();
    chk("wrap_b0", v, 8'hA5);

    // status during read busy, then abort
    cmd(8'hFF);
    wait_rdy();
    cmd(8'h00);
    adr(8'h0F);
    adr(8'h02);
    cmd(8'h30);
    cmd(8'h70);
    rd();
    chk("busy_status_wp1", v, 8'h80);
    wp_n = 1'b0;
    rd();
    chk("busy_status_wp0", v, 8'h00);
    wp_n = 1'b1;
    cmd(8'hFF);
    wait_rdy();
    chk("abort_busy_len", 8'(n), 8'd16);
    cmd(8'h70);
    rd();
    chk("ready_status", v, 8'hE0);

    // illegal cycles
    wr(1'b1, 1'b1, 8'h00);
    chk("cle_ale_err", {7'd0, err}, 8'h01);
    cmd(8'hA5);
    chk("unknown_err", {7'd0, err}, 8'h01);
    rd();
    chk("unknown_idle_oe", {7'd0, oe}, 8'h00);
    chk("unknown_idle_dq", v, 8'hAA);

    // chip disabled cycles are ignored
    ce_n = 1'b1;
    cmd(8'h70);
    wr(1'b1, 1'b1, 8'h00);
    chk("ce_gate_err", {7'd0, err}, 8'h00);
    ce_n = 1'b0;
    rd();
    chk("ce_gate_oe", {7'd0, oe}, 8'h00);

    cmd(8'h00);
    adr(8'h03);
    cmd(8'h30);
    chk("short_addr_err", {7'd0, err}, 8'h01);
    chk("short_addr_rb_n", {7'd0, rb_n}, 8'h01);

`ifdef NAND_TARGET_READ_ID_EN
    cmd(8'h90);
    adr(8'h00);
    rd();
    chk("id0", v, 8'hEC);
    rd();
    chk("id1", v, 8'hDA);
    rd();
    chk("id2", v, 8'h10);
    rd();
    chk("id3", v, 8'h95);
`else
    cmd(8'h90);
    chk("no_id_err", {7'd0, err}, 8'h01);
`endif

    // reset in the middle of a program
    cmd(8'h80);
    adr(8'h00);
    adr(8'h01);
    dat(8'h77);
    cmd(8'h10);
    chk("pg2_rb_n_low", {7'd0, rb_n}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rb_n", {7'd0, rb_n}, 8'h01);
    chk("midrst_dq_oe", {7'd0, dq_oe}, 8'h00);
    chk("midrst_dq_out", dq_out, 8'hAA);
    chk("midrst_cmd_err", {7'd0, cmd_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
